multicycle_maindec: RTL and testbench

//  Parametrised multicycle main decoder FSM for the MIPS datapath. Sequences each instruction through fetch/decode/execute/mem/writeback states.

---
 rtl/maindec_pkg.sv | 46 ++++
 rtl/multicycle_maindec.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_maindec.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/maindec_pkg.sv
// maindec_pkg
//   Shared types and encodings for the multicycle MIPS main decoder:
//   FSM state enum, opcode values and the mux-select encodings driven
//   onto the datapath (alusrcb, pcsrc, aluop).
package maindec_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMRD    = 4'd4,
        MEMWB    = 4'd5,
        MEMWR    = 4'd6,
        EXECUTE  = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        ADDIEXEC = 4'd10,
        ADDIWB   = 4'd11,
        JUMP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALURES = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_maindec.sv
// multicycle_maindec
//   Main decoder FSM for a multicycle MIPS datapath. Steps each instruction
//   through fetch/decode/execute/memory/writeback and handshakes with a
//   shared instruction/data memory (mem_req / mem_ready).
//
//   Ports
//     clk, reset     clock (rising edge), async active-low reset
//     op[5:0]        opcode from the instruction register
//     mem_ready      memory finishes the requested access this cycle
//     mem_req        memory access requested
//     iord .. aluop  datapath control strobes / mux selects
//     byte_enable    current data access is byte-wide (LB/SB)
//     illegal_op     one-cycle pulse in DECODE for an unsupported op
//     instr_done     one-cycle pulse in the last state of an instruction
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   IDLE     | after reset, everything quiet
//   FETCH    | read instruction, PC+4 (waits on mem_ready)
//   DECODE   | register read, branch target, dispatch on op
//   MEMADR   | compute load/store address
//   MEMRD    | data read (waits on mem_ready)
//   MEMWB    | write loaded data to register file
//   MEMWR    | data write (waits on mem_ready)
//   EXECUTE  | R-type ALU operation
//   ALUWB    | write R-type result to rd
//   BRANCH   | compare and conditionally update PC
//   ADDIEXEC | ADDI ALU operation
//   ADDIWB   | write ADDI result to rt
//   JUMP     | PC <= jump target
module multicycle_maindec
    import maindec_pkg::*;
#(
    parameter int SUPPORT_BNE  = 1,
    parameter int SUPPORT_BYTE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       bne,
    output logic       memwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       byte_enable,
    output logic       illegal_op,
    output logic       instr_done
);

    state_t r_state;
    state_t w_next;
    logic   r_byte_q;

    logic   w_is_byte;
    logic   w_is_mem;
    logic   w_is_store;
    logic   w_is_branch;

    always_comb begin
        w_is_byte   = (SUPPORT_BYTE != 0) && ((op == OP_LB) || (op == OP_SB));
        w_is_mem    = (op == OP_LW) || (op == OP_SW) || w_is_byte;
        w_is_store  = (op == OP_SW) || ((SUPPORT_BYTE != 0) && (op == OP_SB));
        w_is_branch = (op == OP_BEQ) || ((SUPPORT_BNE != 0) && (op == OP_BNE));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_byte_q <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE) begin
                r_byte_q <= w_is_byte;
            end
        end
    end

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:     w_next = FETCH;
            FETCH:    w_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                if (w_is_mem)              w_next = MEMADR;
                else if (op == OP_RTYPE)   w_next = EXECUTE;
                else if (w_is_branch)      w_next = BRANCH;
                else if (op == OP_ADDI)    w_next = ADDIEXEC;
                else if (op == OP_J)       w_next = JUMP;
                else                       w_next = FETCH;
            end
            MEMADR:   w_next = w_is_store ? MEMWR : MEMRD;
            MEMRD:    w_next = mem_ready ? MEMWB : MEMRD;
            MEMWB:    w_next = FETCH;
            MEMWR:    w_next = mem_ready ? FETCH : MEMWR;
            EXECUTE:  w_next = ALUWB;
            ALUWB:    w_next = FETCH;
            BRANCH:   w_next = FETCH;
            ADDIEXEC: w_next = ADDIWB;
            ADDIWB:   w_next = FETCH;
            JUMP:     w_next = FETCH;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req     = 1'b0;
        iord        = 1'b0;
        irwrite     = 1'b0;
        pcwrite     = 1'b0;
        branch      = 1'b0;
        bne         = 1'b0;
        memwrite    = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = SRCB_REGB;
        pcsrc       = PCSRC_ALURES;
        aluop       = ALUOP_ADD;
        byte_enable = 1'b0;
        illegal_op  = 1'b0;
        instr_done  = 1'b0;
        case (r_state)
            FETCH: begin
                mem_req = 1'b1;
                alusrcb = SRCB_FOUR;
                // IR and PC only update on the cycle the fetch completes
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            DECODE: begin
                alusrcb = SRCB_IMMSH2;
                if (!w_is_mem && (op != OP_RTYPE) && !w_is_branch &&
                    (op != OP_ADDI) && (op != OP_J)) begin
                    illegal_op = 1'b1;
                    instr_done = 1'b1;
                end
            end
            MEMADR: begin
                alusrca     = 1'b1;
                alusrcb     = SRCB_IMM;
                byte_enable = r_byte_q;
            end
            MEMRD: begin
                mem_req     = 1'b1;
                iord        = 1'b1;
                byte_enable = r_byte_q;
            end
            MEMWB: begin
                memtoreg    = 1'b1;
                regwrite    = 1'b1;
                byte_enable = r_byte_q;
                instr_done  = 1'b1;
            end
            MEMWR: begin
                mem_req     = 1'b1;
                iord        = 1'b1;
                memwrite    = 1'b1;
                byte_enable = r_byte_q;
                instr_done  = mem_ready;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                alusrcb = SRCB_REGB;
                aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                pcsrc      = PCSRC_ALUOUT;
                branch     = 1'b1;
                bne        = (op == OP_BNE);
                instr_done = 1'b1;
            end
            ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            ADDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            JUMP: begin
                pcsrc      = PCSRC_JUMP;
                pcwrite    = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_maindec.sv
// tb_multicycle_maindec
//   Directed bench: one full-feature decoder and one with BNE/byte ops
//   disabled, sharing clock, reset, op and mem_ready. Outputs are packed
//   into a 20-bit control word and compared against hand-built words.
module tb_multicycle_maindec;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'b100011;
    logic       mem_ready = 1'b1;

    logic       a_mem_req, a_iord, a_irwrite, a_pcwrite, a_branch, a_bne, a_memwrite;
    logic       a_regdst, a_memtoreg, a_regwrite, a_alusrca, a_be, a_ill, a_done;
    logic [1:0] a_alusrcb, a_pcsrc, a_aluop;
    logic       b_mem_req, b_iord, b_irwrite, b_pcwrite, b_branch, b_bne, b_memwrite;
    logic       b_regdst, b_memtoreg, b_regwrite, b_alusrca, b_be, b_ill, b_done;
    logic [1:0] b_alusrcb, b_pcsrc, b_aluop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_maindec #(.SUPPORT_BNE(1), .SUPPORT_BYTE(1)) dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .mem_req(a_mem_req), .iord(a_iord), .irwrite(a_irwrite), .pcwrite(a_pcwrite),
        .branch(a_branch), .bne(a_bne), .memwrite(a_memwrite), .regdst(a_regdst),
        .memtoreg(a_memtoreg), .regwrite(a_regwrite), .alusrca(a_alusrca),
        .alusrcb(a_alusrcb), .pcsrc(a_pcsrc), .aluop(a_aluop),
        .byte_enable(a_be), .illegal_op(a_ill), .instr_done(a_done)
    );

    multicycle_maindec #(.SUPPORT_BNE(0), .SUPPORT_BYTE(0)) dut_nb (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .mem_req(b_mem_req), .iord(b_iord), .irwrite(b_irwrite), .pcwrite(b_pcwrite),
        .branch(b_branch), .bne(b_bne), .memwrite(b_memwrite), .regdst(b_regdst),
        .memtoreg(b_memtoreg), .regwrite(b_regwrite), .alusrca(b_alusrca),
        .alusrcb(b_alusrcb), .pcsrc(b_pcsrc), .aluop(b_aluop),
        .byte_enable(b_be), .illegal_op(b_ill), .instr_done(b_done)
    );

    // {mem_req,iord,irwrite,pcwrite,branch,bne,memwrite,regdst,memtoreg,
    //  regwrite,alusrca,alusrcb,pcsrc,aluop,byte_enable,illegal_op,instr_done}
    wire [19:0] w_a = {a_mem_req, a_iord, a_irwrite, a_pcwrite, a_branch, a_bne,
                       a_memwrite, a_regdst, a_memtoreg, a_regwrite, a_alusrca,
                       a_alusrcb, a_pcsrc, a_aluop, a_be, a_ill, a_done};
    wire [19:0] w_b = {b_mem_req, b_iord, b_irwrite, b_pcwrite, b_branch, b_bne,
                       b_memwrite, b_regdst, b_memtoreg, b_regwrite, b_alusrca,
                       b_alusrcb, b_pcsrc, b_aluop, b_be, b_ill, b_done};

    // Hand-written expected control words, one per state/condition
    localparam logic [19:0] E_ZERO   = 20'h00000;
    localparam logic [19:0] E_F_RDY  = {1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0,1'b0};
    localparam logic [19:0] E_F_WAIT = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0,1'b0};
    localparam logic [19:0] E_DEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0,1'b0};
    localparam logic [19:0] E_DEC_IL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b1,1'b1};
    localparam logic [19:0] E_MA_W   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0,1'b0};
    localparam logic [19:0] E_MA_B   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b1,1'b0,1'b0};
    localparam logic [19:0] E_MRD    = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0};
    localparam logic [19:0] E_MWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b1};
    localparam logic [19:0] E_MWR_B  = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0,1'b1};
    localparam logic [19:0] E_MWR_WT = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0};
    localparam logic [19:0] E_MWR_DN = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b1};
    localparam logic [19:0] E_BEQ    = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0,1'b0,1'b1};
    localparam logic [19:0] E_BNE    = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0,1'b0,1'b1};
    localparam logic [19:0] E_JUMP   = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,1'b0,1'b0,1'b1};
    localparam logic [19:0] E_EXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b10,1'b0,1'b0,1'b0};
    localparam logic [19:0] E_ALUWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b1};
    localparam logic [19:0] E_ADDIEX = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0,1'b0};
    localparam logic [19:0] E_ADDIWB = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b1};

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset held from time 0
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", w_a, E_ZERO);
        chk("reset_b", w_b, E_ZERO);
        reset = 1'b1;
        #1;
        chk("idle_a", w_a, E_ZERO);

        // LW with mem_ready held high
        go(); chk("lw_fetch_a", w_a, E_F_RDY); chk("lw_fetch_b", w_b, E_F_RDY);
        go(); chk("lw_dec", w_a, E_DEC);
        go(); chk("lw_memadr", w_a, E_MA_W);
        go(); chk("lw_memrd", w_a, E_MRD);
        go(); chk("lw_memwb_a", w_a, E_MWB); chk("lw_memwb_b", w_b, E_MWB);

        // fetch stalled for three cycles, SB queued
        mem_ready = 1'b0;
        go(); op = 6'b101000; chk("fwait1", w_a, E_F_WAIT);
        go(); chk("fwait2", w_a, E_F_WAIT);
        go(); chk("fwait3_a", w_a, E_F_WAIT); chk("fwait3_b", w_b, E_F_WAIT);
        go(); mem_ready = 1'b1; #1; chk("fwait_done", w_a, E_F_RDY);

        // SB: legal byte store vs illegal when byte ops disabled
        go(); chk("sb_dec_a", w_a, E_DEC); chk("sb_dec_b", w_b, E_DEC_IL);
        go(); chk("sb_memadr_a", w_a, E_MA_B); chk("sb_fetch_b", w_b, E_F_RDY);
        go(); chk("sb_memwr_a", w_a, E_MWR_B); chk("sb_dec2_b", w_b, E_DEC_IL);

        // BEQ, both configurations in lockstep again
        go(); op = 6'b000100; chk("beq_fetch_a", w_a, E_F_RDY); chk("beq_fetch_b", w_b, E_F_RDY);
        go(); chk("beq_dec_b", w_b, E_DEC);
        go(); chk("beq_br_a", w_a, E_BEQ); chk("beq_br_b", w_b, E_BEQ);

        // BNE: taken-on-not-equal vs illegal when disabled
        go(); op = 6'b000101;
        go(); chk("bne_dec_a", w_a, E_DEC); chk("bne_dec_b", w_b, E_DEC_IL);
        go(); chk("bne_br_a", w_a, E_BNE);

        // undefined opcode
        go(); op = 6'b111111;
        go(); chk("ill_dec", w_a, E_DEC_IL);
        go(); chk("ill_refetch", w_a, E_F_RDY);

        // J: jump in cycle 3, then fetch
        op = 6'b000010;
        go(); chk("j_dec", w_a, E_DEC);
        go(); chk("j_jump", w_a, E_JUMP);
        go(); chk("j_fetch", w_a, E_F_RDY);

        // R-type
        op = 6'b000000;
        go();
        go(); chk("r_exec", w_a, E_EXEC);
        go(); chk("r_aluwb", w_a, E_ALUWB);

        // ADDI
        go(); op = 6'b001000;
        go();
        go(); chk("addi_exec", w_a, E_ADDIEX);
        go(); chk("addi_wb", w_a, E_ADDIWB);

        // SW with two wait cycles in MEMWR
        go(); op = 6'b101011;
        go();
        go(); chk("sw_memadr", w_a, E_MA_W); mem_ready = 1'b0;
        go(); chk("sw_wait1", w_a, E_MWR_WT);
        go(); chk("sw_wait2", w_a, E_MWR_WT);
        mem_ready = 1'b1; #1; chk("sw_done", w_a, E_MWR_DN);

        // LW aborted by reset while waiting in MEMRD
        go(); op = 6'b100011;
        go();
        go(); mem_ready = 1'b0;
        go(); chk("abort_memrd", w_a, E_MRD);
        reset = 1'b0;
        #1; chk("abort_reset_a", w_a, E_ZERO); chk("abort_reset_b", w_b, E_ZERO);
        mem_ready = 1'b1;
        go(); chk("abort_held", w_a, E_ZERO);
        reset = 1'b1;
        #1; chk("abort_idle", w_a, E_ZERO);
        go(); chk("abort_fetch_a", w_a, E_F_RDY); chk("abort_fetch_b", w_b, E_F_RDY);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
